// File: rtl/vh_parity_codec_pipe.sv
// Pipelined row/column parity codec: encode + channel error injection, syndrome, then
// single-error correction with valid/ready flow control and saturating error counters.
module vh_parity_codec_pipe #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CNT_W  = 16,
  localparam int DATA_W = ROWS * COLS,
  localparam int CW_W   = DATA_W + ROWS + COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CW_W-1:0]   bit_flip,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Row parities in the low ROWS bits, column parities above them.
  function automatic logic [ROWS+COLS-1:0] calc_parity(input logic [DATA_W-1:0] d);
    logic [ROWS+COLS-1:0] p;
    p = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        p[r]        = p[r] ^ d[r*COLS+c];
        p[ROWS+c]   = p[ROWS+c] ^ d[r*COLS+c];
      end
    end
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              vld_p1_q, vld_p2_q, vld_p3_q;
  logic [CW_W-1:0]   cw_p1_q;
  logic              cen_p1_q, cen_p2_q;
  logic [DATA_W-1:0] data_p2_q, data_p3_q;
  logic [ROWS-1:0]   rs_p2_q;
  logic [COLS-1:0]   cs_p2_q;
  logic              corr_p3_q, uncorr_p3_q;
  logic [CNT_W-1:0]  corr_cnt_q, uncorr_cnt_q;

  logic rdy_p1, rdy_p2, rdy_p3;
  assign rdy_p3   = !vld_p3_q || out_ready;
  assign rdy_p2   = !vld_p2_q || rdy_p3;
  assign rdy_p1   = !vld_p1_q || rdy_p2;
  assign in_ready = rdy_p1;

  // S1: encode and inject the channel error pattern
  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else if (rdy_p1) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (rdy_p1 && in_valid) begin
      cw_p1_q  <= {calc_parity(data_in), data_in} ^ bit_flip;
      cen_p1_q <= correct_en;
    end
  end

  // S2: syndrome = recomputed parity XOR received parity
  logic [ROWS+COLS-1:0] syn_d;
  assign syn_d = calc_parity(cw_p1_q[DATA_W-1:0]) ^ cw_p1_q[CW_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) vld_p2_q <= 1'b0;
    else if (rdy_p2) vld_p2_q <= vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rdy_p2 && vld_p1_q) begin
      data_p2_q <= cw_p1_q[DATA_W-1:0];
      rs_p2_q   <= syn_d[ROWS-1:0];
      cs_p2_q   <= syn_d[ROWS+COLS-1:ROWS];
      cen_p2_q  <= cen_p1_q;
    end
  end

  // S3: classify the syndrome and correct a single data-bit error
  logic [DATA_W-1:0] mask_d, dec_d;
  logic              hit_data_d, corr_d, uncorr_d;
  always_comb begin
    mask_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mask_d[r*COLS+c] = rs_p2_q[r] & cs_p2_q[c];
      end
    end
    hit_data_d = $onehot(rs_p2_q) && $onehot(cs_p2_q);
    corr_d     = hit_data_d ||
                 ($onehot(rs_p2_q) && (cs_p2_q == '0)) ||
                 ((rs_p2_q == '0) && $onehot(cs_p2_q));
    uncorr_d   = !corr_d && ((rs_p2_q != '0) || (cs_p2_q != '0));
    dec_d      = (hit_data_d && cen_p2_q) ? (data_p2_q ^ mask_d) : data_p2_q;
  end

  logic load_p3;
  assign load_p3 = rdy_p3 && vld_p2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3_q     <= 1'b0;
      data_p3_q    <= '0;
      corr_p3_q    <= 1'b0;
      uncorr_p3_q  <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      if (rdy_p3) vld_p3_q <= vld_p2_q;
      if (load_p3) begin
        data_p3_q   <= dec_d;
        corr_p3_q   <= corr_d;
        uncorr_p3_q <= uncorr_d;
      end
      // A clear on the same edge wins over the increment.
      if (cnt_clr) begin
        corr_cnt_q   <= '0;
        uncorr_cnt_q <= '0;
      end else if (load_p3) begin
        if (corr_d)   corr_cnt_q   <= sat_inc(corr_cnt_q);
        if (uncorr_d) uncorr_cnt_q <= sat_inc(uncorr_cnt_q);
      end
    end
  end

  assign out_valid  = vld_p3_q;
  assign data_out   = data_p3_q;
  assign err_corr   = corr_p3_q;
  assign err_uncorr = uncorr_p3_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_vh_parity_codec_pipe.sv
// Randomized and directed bench for vh_parity_codec_pipe (ROWS=COLS=4, CNT_W=2) with a
// syndrome-from-error-pattern reference model and an in-order scoreboard.
module tb_vh_parity_codec_pipe;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int CW   = 24;

  logic          clk;
  logic          rst, in_valid, out_ready, correct_en, cnt_clr;
  logic [DW-1:0] data_in;
  logic [CW-1:0] bit_flip;
  logic          in_ready, out_valid, err_corr, err_uncorr;
  logic [DW-1:0] data_out;
  logic [1:0]    corr_cnt, uncorr_cnt;

  vh_parity_codec_pipe #(.ROWS(ROWS), .COLS(COLS), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .bit_flip(bit_flip), .correct_en(correct_en),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          c;
    logic          u;
  } beat_t;

  beat_t      exp_q[$];
  logic       front_counted;
  logic [1:0] mc_c, mc_u;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_deliv = 0;
  logic       last_acc, last_blocked;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // The syndrome depends only on the error pattern, so it is derived from bit_flip alone.
  function automatic beat_t model(input logic [DW-1:0] d, input logic [CW-1:0] f, input logic cen);
    beat_t b;
    int nr, nc, rr, cc, ones;
    nr = 0; nc = 0; rr = 0; cc = 0;
    for (int r = 0; r < ROWS; r++) begin
      ones = int'(f[DW+r]);
      for (int c = 0; c < COLS; c++) ones += int'(f[r*COLS+c]);
      if (ones % 2 == 1) begin nr++; rr = r; end
    end
    for (int c = 0; c < COLS; c++) begin
      ones = int'(f[DW+ROWS+c]);
      for (int r = 0; r < ROWS; r++) ones += int'(f[r*COLS+c]);
      if (ones % 2 == 1) begin nc++; cc = c; end
    end
    b.d = d ^ f[DW-1:0];
    b.c = (nr + nc == 1) || (nr == 1 && nc == 1);
    b.u = (nr + nc > 0) && !b.c;
    if (cen && nr == 1 && nc == 1) b.d[rr*COLS+cc] = ~b.d[rr*COLS+cc];
    return b;
  endfunction

  function automatic logic [1:0] sinc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  function automatic logic [CW-1:0] rand_flip();
    logic [CW-1:0] f;
    int a, b;
    f = '0;
    case ($urandom % 4)
      0: f = '0;
      1: f[$urandom_range(0, CW-1)] = 1'b1;
      2: begin
        a = $urandom_range(0, CW-1);
        b = (a + $urandom_range(1, CW-1)) % CW;
        f[a] = 1'b1; f[b] = 1'b1;
      end
      default: f = CW'($urandom);
    endcase
    return f;
  endfunction

  // One clock: called at the falling edge with inputs already driven.
  task automatic step();
    logic          del, clr, hold_v, hold_c, hold_u;
    logic [DW-1:0] hold_d;
    beat_t         b;
    #1;
    check_eq("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 3 && !out_ready)));
    if (exp_q.size() == 0) check_eq("idle_out_valid", 32'(out_valid), 32'd0);
    last_acc     = in_valid && in_ready;
    last_blocked = in_valid && !in_ready;
    del = out_valid && out_ready && exp_q.size() > 0;
    if (del) begin
      b = exp_q.pop_front();
      check_eq("data_out", 32'(data_out), 32'(b.d));
      check_eq("err_corr", 32'(err_corr), 32'(b.c));
      check_eq("err_uncorr", 32'(err_uncorr), 32'(b.u));
      front_counted = 1'b0;
      n_deliv++;
    end
    if (last_acc) exp_q.push_back(model(data_in, bit_flip, correct_en));
    hold_v = out_valid && !out_ready;
    hold_d = data_out; hold_c = err_corr; hold_u = err_uncorr;
    clr = cnt_clr;
    @(posedge clk);
    #1;
    if (clr) begin mc_c = 2'd0; mc_u = 2'd0; end
    if (out_valid && exp_q.size() > 0 && !front_counted) begin
      front_counted = 1'b1;
      if (!clr) begin
        if (exp_q[0].c) mc_c = sinc(mc_c);
        if (exp_q[0].u) mc_u = sinc(mc_u);
      end
    end
    check_eq("corr_cnt", 32'(corr_cnt), 32'(mc_c));
    check_eq("uncorr_cnt", 32'(uncorr_cnt), 32'(mc_u));
    if (hold_v) begin
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_data", 32'(data_out), 32'(hold_d));
      check_eq("stall_flags", 32'({err_corr, err_uncorr}), 32'({hold_c, hold_u}));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    front_counted = 1'b0; mc_c = 2'd0; mc_u = 2'd0;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_flags", 32'({err_corr, err_uncorr}), 32'd0);
    check_eq("rst_counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic send_one(input logic [DW-1:0] d, input logic [CW-1:0] f, input logic cen,
                          input logic [DW-1:0] ed, input logic ec, input logic eu);
    out_ready = 1'b1; in_valid = 1'b1; data_in = d; bit_flip = f; correct_en = cen;
    step();
    in_valid = 1'b0;
    step();
    check_eq("lat_edge1", 32'(out_valid), 32'd0);
    step();
    check_eq("lat_edge2", 32'(out_valid), 32'd1);
    check_eq("dir_data", 32'(data_out), 32'(ed));
    check_eq("dir_corr", 32'(err_corr), 32'(ec));
    check_eq("dir_uncorr", 32'(err_uncorr), 32'(eu));
    step();
  endtask

  initial begin
    int sent, d0;
    logic saw_block;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; correct_en = 1'b1; cnt_clr = 1'b0;
    data_in = '0; bit_flip = '0;
    front_counted = 1'b0; mc_c = 2'd0; mc_u = 2'd0;
    @(negedge clk);
    do_reset();

    send_one(16'hA5C3, 24'h000000, 1'b1, 16'hA5C3, 1'b0, 1'b0);
    send_one(16'hA5C3, 24'h000020, 1'b1, 16'hA5C3, 1'b1, 1'b0);
    send_one(16'hA5C3, 24'h000020, 1'b0, 16'hA5E3, 1'b1, 1'b0);
    send_one(16'h1234, 24'h010000, 1'b1, 16'h1234, 1'b1, 1'b0);
    send_one(16'h1234, 24'h100000, 1'b1, 16'h1234, 1'b1, 1'b0);
    send_one(16'h5A5A, 24'h000003, 1'b1, 16'h5A59, 1'b0, 1'b1);
    send_one(16'h5A5A, 24'h000021, 1'b1, 16'h5A7B, 1'b0, 1'b1);

    // Counter saturation at CNT_W=2, then clear colliding with an increment.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check_eq("clr_cnt", 32'(corr_cnt), 32'd0);
    out_ready = 1'b1; correct_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; data_in = DW'($urandom); bit_flip = '0; bit_flip[i*3] = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("corr_sat", 32'(corr_cnt), 32'd3);
    in_valid = 1'b1; data_in = 16'hBEEF; bit_flip = 24'h000400; step();
    in_valid = 1'b0; step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check_eq("clr_priority", 32'(corr_cnt), 32'd0);
    step();

    // Eight beats against a 1,0,0 out_ready pattern.
    sent = 0; saw_block = 1'b0; d0 = n_deliv;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (sent >= 8 && exp_q.size() == 0) break;
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      data_in   = DW'(16'h1100 + sent);
      bit_flip  = (sent % 2 == 0) ? 24'h000000 : (24'h1 << sent);
      step();
      if (last_acc) sent++;
      if (last_blocked) saw_block = 1'b1;
    end
    check_eq("stream_delivered", 32'(n_deliv - d0), 32'd8);
    check_eq("stream_backpressure", 32'(saw_block), 32'd1);

    // Random traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 3) != 0;
      cnt_clr    = ($urandom % 32) == 0;
      correct_en = ($urandom % 4) != 0;
      data_in    = DW'($urandom);
      bit_flip   = rand_flip();
      step();
    end
    cnt_clr = 1'b0;

    // Reset with beats in flight: none may reappear.
    out_ready = 1'b0; in_valid = 1'b1; bit_flip = 24'h000001;
    for (int i = 0; i < 4; i++) begin data_in = DW'($urandom); step(); end
    do_reset();
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    send_one(16'h0F0F, 24'h800000, 1'b1, 16'h0F0F, 1'b1, 1'b0);

    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
